// File: rtl/aq_gemac_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32 and frame length, strips the FCS.
// Build option RX_FCS_PASS_EN: deliver the FCS bytes with the payload instead of stripping them.
module aq_gemac_rx_frame #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        rx_clk,
    input  logic        rst_b,
    input  logic [7:0]  bgmii_rxd,
    input  logic        bgmii_rxe,
    input  logic        bgmii_rxer,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_done,
    output logic        rx_crc_err,
    output logic        rx_err,
    output logic [15:0] rx_len
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned CRC_W = 32;
    localparam int unsigned FCS_N = 4;
    localparam logic [7:0]       PRE_BYTE    = 8'h55;
    localparam logic [7:0]       SFD_BYTE    = 8'hD5;
    localparam logic [CRC_W-1:0] CRC_POLY_R  = 32'hEDB88320;
    localparam logic [CRC_W-1:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_e;

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rxer_seen_q, rxer_seen_d;
    logic             ovl_q, ovl_d;
    logic             from_data_q, from_data_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_sof_q, rx_sof_d;
    logic             rx_done_q, rx_done_d;
    logic             rx_crc_err_q, rx_crc_err_d;
    logic             rx_err_q, rx_err_d;
    logic [CNT_W-1:0] rx_len_q, rx_len_d;
`ifndef RX_FCS_PASS_EN
    logic [FCS_N-1:0][7:0] dly_q, dly_d;
`endif

    logic             enter_data;
    logic [CNT_W-1:0] stat_len;
    logic             stat_err;
    logic             stat_crc_err;

    // Reflected CRC-32, data consumed LSB first
    function automatic logic [CRC_W-1:0] crc_upd(input logic [CRC_W-1:0] c, input logic [7:0] d);
        logic [CRC_W-1:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    // End-of-frame status from the accumulated frame state
`ifdef RX_FCS_PASS_EN
    assign stat_len = cnt_q;
`else
    assign stat_len = (cnt_q < CNT_W'(FCS_N)) ? '0 : cnt_q - CNT_W'(FCS_N);
`endif
    assign stat_err     = rxer_seen_q | ovl_q | (cnt_q < CNT_W'(MIN_LEN));
    assign stat_crc_err = (bit_rev(crc_q) != CRC_RESIDUE);

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        rxer_seen_d  = rxer_seen_q;
        ovl_d        = ovl_q;
        from_data_d  = from_data_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_sof_d     = 1'b0;
        rx_done_d    = 1'b0;
        rx_crc_err_d = rx_crc_err_q;
        rx_err_d     = rx_err_q;
        rx_len_d     = rx_len_q;
        enter_data   = 1'b0;
`ifndef RX_FCS_PASS_EN
        dly_d        = dly_q;
`endif

        case (state_q)
            IDLE: begin
                if (bgmii_rxe) begin
                    if (bgmii_rxd == PRE_BYTE) begin
                        state_d = PRE;
                    end else if (bgmii_rxd == SFD_BYTE) begin
                        enter_data = 1'b1;
                    end else begin
                        state_d     = DROP;
                        from_data_d = 1'b0;
                    end
                end
            end
            PRE: begin
                if (!bgmii_rxe) begin
                    state_d = IDLE;
                end else if (bgmii_rxd == SFD_BYTE) begin
                    enter_data = 1'b1;
                end else if (bgmii_rxd != PRE_BYTE) begin
                    state_d     = DROP;
                    from_data_d = 1'b0;
                end
            end
            DATA: begin
                if (!bgmii_rxe) begin
                    state_d      = IDLE;
                    rx_done_d    = 1'b1;
                    rx_crc_err_d = stat_crc_err;
                    rx_err_d     = stat_err;
                    rx_len_d     = stat_len;
                end else if (cnt_q == CNT_W'(MAX_LEN)) begin
                    // Byte that would make the count MAX_LEN+1 is discarded uncounted
                    state_d     = DROP;
                    ovl_d       = 1'b1;
                    from_data_d = 1'b1;
                end else begin
                    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    crc_d       = crc_upd(crc_q, bgmii_rxd);
                    rxer_seen_d = rxer_seen_q | bgmii_rxer;
`ifdef RX_FCS_PASS_EN
                    rx_data_d  = bgmii_rxd;
                    rx_valid_d = 1'b1;
                    rx_sof_d   = (cnt_q == '0);
`else
                    if (cnt_q >= CNT_W'(FCS_N)) begin
                        rx_data_d  = dly_q[FCS_N-1];
                        rx_valid_d = 1'b1;
                        rx_sof_d   = (cnt_q == CNT_W'(FCS_N));
                    end
                    dly_d = {dly_q[FCS_N-2:0], bgmii_rxd};
`endif
                end
            end
            DROP: begin
                if (!bgmii_rxe) begin
                    state_d     = IDLE;
                    from_data_d = 1'b0;
                    if (from_data_q) begin
                        rx_done_d    = 1'b1;
                        rx_crc_err_d = stat_crc_err;
                        rx_err_d     = stat_err;
                        rx_len_d     = stat_len;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_data) begin
            state_d     = DATA;
            crc_d       = '1;
            cnt_d       = '0;
            rxer_seen_d = 1'b0;
            ovl_d       = 1'b0;
            from_data_d = 1'b0;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            crc_q        <= '0;
            cnt_q        <= '0;
            rxer_seen_q  <= 1'b0;
            ovl_q        <= 1'b0;
            from_data_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_sof_q     <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_crc_err_q <= 1'b0;
            rx_err_q     <= 1'b0;
            rx_len_q     <= '0;
`ifndef RX_FCS_PASS_EN
            dly_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            rxer_seen_q  <= rxer_seen_d;
            ovl_q        <= ovl_d;
            from_data_q  <= from_data_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_sof_q     <= rx_sof_d;
            rx_done_q    <= rx_done_d;
            rx_crc_err_q <= rx_crc_err_d;
            rx_err_q     <= rx_err_d;
            rx_len_q     <= rx_len_d;
`ifndef RX_FCS_PASS_EN
            dly_q        <= dly_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_sof     = rx_sof_q;
    assign rx_done    = rx_done_q;
    assign rx_crc_err = rx_crc_err_q;
    assign rx_err     = rx_err_q;
    assign rx_len     = rx_len_q;

endmodule

// File: tb/tb_aq_gemac_rx_frame.sv
// Bench for aq_gemac_rx_frame: random frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_aq_gemac_rx_frame;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        rx_clk = 1'b0;
    logic        rst_b;
    logic [7:0]  bgmii_rxd;
    logic        bgmii_rxe;
    logic        bgmii_rxer;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_done;
    logic        rx_crc_err;
    logic        rx_err;
    logic [15:0] rx_len;

    aq_gemac_rx_frame #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .rx_clk(rx_clk), .rst_b(rst_b),
        .bgmii_rxd(bgmii_rxd), .bgmii_rxe(bgmii_rxe), .bgmii_rxer(bgmii_rxer),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_done(rx_done),
        .rx_crc_err(rx_crc_err), .rx_err(rx_err), .rx_len(rx_len)
    );

    always #4 rx_clk = ~rx_clk;

    int tests;
    int fails;
    int proto_err;

    logic [7:0]  frm[$];
    logic        frm_er[$];
    logic [7:0]  exp_b[$], got_b[$];
    logic        exp_s[$], got_s[$];
    logic [15:0] exp_len[$], got_len[$];
    logic        exp_cerr[$], got_cerr[$];
    logic        exp_err[$], got_err[$];

    // Output monitor, sampled on the falling edge
    always @(negedge rx_clk) begin
        if (rx_valid) begin
            got_b.push_back(rx_data);
            got_s.push_back(rx_sof);
        end
        if (rx_sof && !rx_valid) proto_err++;
        if (rx_valid && rx_done) proto_err++;
        if (rx_done) begin
            got_len.push_back(rx_len);
            got_cerr.push_back(rx_crc_err);
            got_err.push_back(rx_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Standard Ethernet FCS value of frm[0..nb-1]
    function automatic logic [31:0] crc32_of(input int nb);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < nb; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int plen, input int er_idx, input int bad_idx);
        logic [31:0] c;
        frm.delete();
        frm_er.delete();
        for (int i = 0; i < plen; i++) begin
            frm.push_back(8'($urandom));
            frm_er.push_back(1'b0);
        end
        c = crc32_of(plen);
        for (int i = 0; i < 4; i++) begin
            frm.push_back(c[8*i +: 8]);
            frm_er.push_back(1'b0);
        end
        if (er_idx >= 0) frm_er[er_idx] = 1'b1;
        if (bad_idx >= 0) frm[bad_idx] = frm[bad_idx] ^ 8'(1 << $urandom_range(7, 0));
    endtask

    // Expected deliveries for the frame in frm (always at least 4 bytes)
    task automatic model_frame();
        int n, cnt, emit;
        logic er;
        logic [31:0] fcs;
        n   = frm.size();
        cnt = (n > MAX_LEN) ? MAX_LEN : n;
        er  = (n > MAX_LEN) || (cnt < MIN_LEN);
        for (int i = 0; i < cnt; i++) if (frm_er[i]) er = 1'b1;
        fcs = {frm[cnt-1], frm[cnt-2], frm[cnt-3], frm[cnt-4]};
`ifdef RX_FCS_PASS_EN
        emit = cnt;
`else
        emit = cnt - 4;
`endif
        for (int i = 0; i < emit; i++) begin
            exp_b.push_back(frm[i]);
            exp_s.push_back(i == 0);
        end
        exp_len.push_back(16'(emit));
        exp_cerr.push_back(crc32_of(cnt - 4) != fcs);
        exp_err.push_back(er);
    endtask

    task automatic drive(input logic e, input logic [7:0] d, input logic er);
        @(negedge rx_clk);
        bgmii_rxe  = e;
        bgmii_rxd  = d;
        bgmii_rxer = er;
    endtask

    task automatic send_frame(input int pre_n, input int gap);
        for (int i = 0; i < pre_n; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], frm_er[i]);
        for (int i = 0; i < gap; i++) drive(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic flush_got();
        got_b.delete(); got_s.delete(); got_len.delete(); got_cerr.delete(); got_err.delete();
        proto_err = 0;
    endtask

    task automatic check_frames(input string tag);
        int mism, nb, nd;
        for (int i = 0; i < 4; i++) drive(1'b0, 8'($urandom), 1'b0);
        chk({tag, "_proto"}, 32'(proto_err), 32'd0);
        chk({tag, "_nbytes"}, 32'(got_b.size()), 32'(exp_b.size()));
        nb = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        mism = 0;
        for (int i = 0; i < nb; i++)
            if (got_b[i] !== exp_b[i] || got_s[i] !== exp_s[i]) mism++;
        chk({tag, "_bytes"}, 32'(mism), 32'd0);
        chk({tag, "_ndone"}, 32'(got_len.size()), 32'(exp_len.size()));
        nd = (got_len.size() < exp_len.size()) ? got_len.size() : exp_len.size();
        for (int i = 0; i < nd; i++) begin
            chk({tag, "_len"}, 32'(got_len[i]), 32'(exp_len[i]));
            chk({tag, "_crcerr"}, 32'(got_cerr[i]), 32'(exp_cerr[i]));
            chk({tag, "_err"}, 32'(got_err[i]), 32'(exp_err[i]));
        end
        exp_b.delete(); exp_s.delete(); exp_len.delete(); exp_cerr.delete(); exp_err.delete();
        flush_got();
    endtask

    initial begin
        int plen, er_idx, bad_idx;
        tests = 0;
        fails = 0;
        proto_err = 0;
        rst_b = 1'b0;
        bgmii_rxe = 1'b0;
        bgmii_rxd = 8'h00;
        bgmii_rxer = 1'b0;
        repeat (3) @(negedge rx_clk);
        chk("reset_outs", 32'({rx_data, rx_valid, rx_sof, rx_done, rx_crc_err, rx_err, rx_len}), 32'd0);
        rst_b = 1'b1;

        build_frame(60, -1, -1); model_frame(); send_frame(7, 2); check_frames("good60");
        build_frame(60, -1, 10); model_frame(); send_frame(7, 2); check_frames("bad_crc");
        build_frame(36, -1, -1); model_frame(); send_frame(0, 2); check_frames("runt");
        build_frame(60, 20, -1); model_frame(); send_frame(7, 2); check_frames("rxer");

        // Corrupt preamble: frame is dropped silently
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h12, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check_frames("bad_pre");
        build_frame($urandom_range(120, 60), -1, -1); model_frame(); send_frame(7, 2);
        check_frames("after_bad_pre");

        // Back-to-back frames with a single idle cycle between them
        build_frame(70, -1, -1); model_frame(); send_frame(7, 1);
        build_frame(62, -1, -1); model_frame(); send_frame(2, 2);
        check_frames("b2b");

        for (int f = 0; f < 6; f++) begin
            plen    = int'($urandom_range(120, 0));
            er_idx  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(plen + 3, 0)) : -1;
            bad_idx = ($urandom_range(2, 0) == 0) ? int'($urandom_range(plen + 3, 0)) : -1;
            build_frame(plen, er_idx, bad_idx);
            model_frame();
            send_frame(int'($urandom_range(7, 0)), int'($urandom_range(3, 1)));
        end
        check_frames("random");

        build_frame(1596, -1, -1); model_frame(); send_frame(7, 2); check_frames("overlength");

        // Reset pulse mid-frame with rxe held high on a non-preamble byte
        build_frame(100, -1, -1);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, frm[i], 1'b0);
        @(posedge rx_clk);
        #1 rst_b = 1'b0;
        flush_got();
        drive(1'b1, 8'h3C, 1'b0);
        chk("mid_reset_outs", 32'({rx_data, rx_valid, rx_sof, rx_done, rx_crc_err, rx_err, rx_len}), 32'd0);
        drive(1'b1, 8'h3C, 1'b0);
        rst_b = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check_frames("rst_drop");
        build_frame(64, -1, -1); model_frame(); send_frame(7, 2); check_frames("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aq_gemac_rx_frame.md
Name: aq_gemac_rx_frame

Overview:
Receive-side framer directly downstream of the GMII I/O buffer stage, clocked by rx_clk. Takes the registered GMII RX byte stream, detects preamble/SFD and strips both, then checks CRC-32 and frame length. Delivers payload bytes (destination MAC through end of data) to the MAC RX FIFO/parser, followed by a one-cycle end-of-frame status pulse.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes, counted from the first byte after the SFD and including the FCS.
MAX_LEN, 1518, maximum legal frame length in bytes, including the FCS.

Ports:
rx_clk  in  1  receive clock; all logic on the rising edge.
rst_b  in  1  reset, asynchronous, active-low.
bgmii_rxd  in  8  buffered GMII receive data.
bgmii_rxe  in  1  buffered GMII receive data valid.
bgmii_rxer  in  1  buffered GMII receive error.
rx_data  out  8  payload byte.
rx_valid  out  1  rx_data is valid this cycle.
rx_sof  out  1  first payload byte of the frame; only asserted together with rx_valid.
rx_done  out  1  one-cycle end-of-frame strobe.
rx_crc_err  out  1  FCS mismatch; valid when rx_done is high.
rx_err  out  1  rxer seen, runt, or overlength; valid when rx_done is high.
rx_len  out  16  payload length in bytes (FCS excluded); valid when rx_done is high.

Behaviour:
- Reset: rx_data=0, rx_valid=0, rx_sof=0, rx_done=0, rx_crc_err=0, rx_err=0, rx_len=0, state=IDLE. The CRC register, counter and delay line are also cleared.
- State machine: IDLE, PRE, DATA, DROP.
  - IDLE:
    - rxe=1 and rxd=0x55 -> PRE.
    - rxe=1 and rxd=0xD5 -> DATA (short preamble accepted).
    - rxe=1 with any other byte -> DROP.
  - PRE:
    - rxd=0x55 -> stay in PRE.
    - rxd=0xD5 -> DATA.
    - any other byte -> DROP.
    - rxe=0 -> IDLE, with no rx_done.
  - DATA:
    - each byte with rxe=1 is counted, CRC-updated and pushed into the delay line.
    - rxe=0 -> IDLE and issue rx_done.
    - when the count reaches MAX_LEN+1 -> DROP with the overlength flag set.
  - DROP:
    - wait for rxe=0, then -> IDLE.
    - rx_done is issued only if DROP was entered from DATA; a bad preamble gives no rx_done.
- Entering DATA initialises CRC to 0xFFFFFFFF, the counter to 0, and clears all error flags.
- CRC-32 (poly 0x04C11DB7, reflected, LSB first) runs over every byte after the SFD, FCS included. The frame is good if the final register equals residue 0xC704DD7B; otherwise rx_crc_err=1.
- Byte counter: 16-bit, saturates at 0xFFFF.
  - runt if count < MIN_LEN.
  - rx_len = count-4, clamped to 0 when count < 4.
- rxer=1 on any byte while in DATA sets the sticky rx_err; reception continues to the end of the frame.
- FCS stripping: a 4-byte delay line holds the last 4 bytes received.
  - When byte i+4 is sampled, byte i is registered onto rx_data; rx_valid is high in the following cycle.
  - The first byte emitted carries rx_sof.
  - When the frame ends, the 4 bytes left in the delay line are the FCS and are discarded.
  - A frame of 4 bytes or fewer emits no data.
- rx_done:
  - asserted for one cycle, registered, in the cycle after rxe is sampled low.
  - rx_crc_err, rx_err and rx_len update in the same cycle and hold until the next rx_done.
- rx_valid is never asserted in the same cycle as rx_done for the same frame.
- rxe rising in the cycle after rxe falls (no inter-frame gap) is handled: rx_done for frame N and the preamble of frame N+1 are processed concurrently.
- Reset mid-frame: outputs go to reset values. If rxe is still high when reset releases and rxd is neither 0x55 nor 0xD5, the FSM goes to DROP.

Optional Feature:
RX_FCS_PASS_EN.
- Defined: no delay line; byte i appears one cycle after it is sampled, FCS bytes included. rx_len includes the FCS (rx_len=count). CRC checking is unchanged.
- Undefined: 4-byte delay line; FCS stripped, as described above.

Test Plan:
- 7x0x55, 0xD5, then 60 payload bytes + correct FCS -> 60 rx_valid bytes, rx_sof on byte 0, then rx_done with rx_len=60, rx_crc_err=0, rx_err=0.
- Same frame with payload byte 10 corrupted -> rx_crc_err=1, rx_err=0, rx_len=60.
- 0xD5 + 40 bytes incl. good FCS -> rx_done with rx_err=1 (runt), rx_len=36.
- rxer=1 on byte 20 of a 64-byte good frame -> rx_err=1, rx_crc_err=0, all 60 bytes still delivered.
- Preamble 0x55,0x55,0x12,... -> no rx_valid and no rx_done until the next frame; next good frame is received correctly.
- 1600-byte frame -> 1514 bytes emitted, rx_done with rx_err=1, rx_len=1514. Then rst_b pulsed mid-frame -> all outputs 0 within the reset, and the next good frame is received cleanly.
